text_cell_writer: RTL and testbench

- Producer side of the on-screen text path. It accepts ASCII bytes over a valid/ready stream and writes them into the character-cell RAM at a hardware cursor.
- The sprite address logic later reads that RAM per 8x16 cell to fetch font rows.
- It also provides a full-screen clear that fills the RAM with spaces.
- The screen is 640x480, which gives 80 columns x 30 rows of cells.

---
 rtl/text_cell_writer.sv | 120 ++++++++++++
 tb/tb_text_cell_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/text_cell_writer.sv
// Text cell writer: takes ASCII bytes from a valid/ready stream and writes them into the
// character-cell RAM at a wrapping cursor, and fills the RAM with spaces on request.
// Optional macro TEXT_CELL_CTRL_EN enables handling of the LF, CR and BS control bytes.
module text_cell_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              clear_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy,
    output logic              dbg_state
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    state_t            r_state;
    logic [6:0]        r_col;
    logic [4:0]        r_row;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic              w_accept;
    logic              w_printable;
    logic              w_col_last;
    logic [4:0]        w_row_next;
    logic [ADDR_W-1:0] w_cur_addr;

    // Stream handshake: a byte transfers on any rising edge where char_valid && char_ready.
    // A pending clear request takes priority, so the source must hold its byte meanwhile.
    assign char_ready  = (r_state == IDLE) && !clear_req && Reset;
    assign w_accept    = char_valid && char_ready;
    assign w_printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign w_col_last  = (r_col == 7'(COLS - 1));
    assign w_row_next  = (r_row == 5'(ROWS - 1)) ? 5'd0 : r_row + 5'd1;
    assign w_cur_addr  = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_col     <= 7'd0;
            r_row     <= 5'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wr_en <= 1'b0;
                    if (clear_req) begin
                        // First fill write is issued on the entry edge so busy and wr_en align.
                        r_state   <= CLEAR;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= 8'h20;
                    end else if (w_accept) begin
                        if (w_printable) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_cur_addr;
                            r_wr_data <= char_in;
                            if (w_col_last) begin
                                r_col <= 7'd0;
                                r_row <= w_row_next;
                            end else begin
                                r_col <= r_col + 7'd1;
                            end
                        end
`ifdef TEXT_CELL_CTRL_EN
                        else if (char_in == 8'h0A) begin
                            r_col <= 7'd0;
                            r_row <= w_row_next;
                        end else if (char_in == 8'h0D) begin
                            r_col <= 7'd0;
                        end else if (char_in == 8'h08 && r_col != 7'd0) begin
                            r_col     <= r_col - 7'd1;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_cur_addr - ADDR_W'(1);
                            r_wr_data <= 8'h20;
                        end
`endif
                    end
                end
                CLEAR: begin
                    if (r_wr_addr == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_wr_en <= 1'b0;
                        r_col   <= 7'd0;
                        r_row   <= 5'd0;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        r_wr_data <= 8'h20;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign busy       = (r_state == CLEAR);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_text_cell_writer.sv
// Directed bench for text_cell_writer: writes, cursor wrap, clear, reset abort, control bytes.
module tb_text_cell_writer;

    logic        Clk;
    logic        Reset;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        clear_req;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;
    logic        dbg_state;

    int vectors;
    int miscompares;
    int seq_err;

    text_cell_writer #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input logic [11:0] addr, input logic [7:0] data);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, "_addr"}, 32'(wr_addr), 32'(addr));
        chk({tag, "_data"}, 32'(wr_data), 32'(data));
    endtask

    task automatic chk_cursor(input string tag, input int col, input int row);
        chk({tag, "_col"}, 32'(cursor_col), 32'(col));
        chk({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b0;
        char_in     = 8'h00;
        char_valid  = 1'b0;
        clear_req   = 1'b0;

        // Reset values
        #1;
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk_cursor("rst", 0, 0);
        tick;
        tick;
        Reset = 1'b1;
        #1;
        chk("idle_ready", 32'(char_ready), 32'd1);

        // "AB" back to back
        char_in = 8'h41; char_valid = 1'b1;
        tick;
        chk_write("a", 12'd0, 8'h41);
        chk_cursor("a", 1, 0);
        char_in = 8'h42;
        tick;
        chk_write("b", 12'd1, 8'h42);
        chk_cursor("b", 2, 0);
        char_valid = 1'b0;
        tick;
        chk("ab_done_wr_en", 32'(wr_en), 32'd0);

        // Fill to (79,0), then end-of-row wrap
        char_in = 8'h2E; char_valid = 1'b1;
        repeat (77) @(posedge Clk);
        #1;
        chk_cursor("fill79", 79, 0);
        chk("fill79_addr", 32'(wr_addr), 32'd78);
        char_in = 8'h5A;
        tick;
        chk_write("rowwrap", 12'd79, 8'h5A);
        chk_cursor("rowwrap", 0, 1);

        // Fill to (79,29), then end-of-screen wrap
        char_in = 8'h2E;
        repeat (2319) @(posedge Clk);
        #1;
        chk_cursor("fill2399", 79, 29);
        char_in = 8'h21;
        tick;
        chk_write("scrwrap", 12'd2399, 8'h21);
        chk_cursor("scrwrap", 0, 0);

        // Non-printable bytes are consumed without a write
        char_in = 8'h7F;
        tick;
        chk("np7f_wr_en", 32'(wr_en), 32'd0);
        chk_cursor("np7f", 0, 0);
        char_in = 8'h1F;
        tick;
        chk("np1f_wr_en", 32'(wr_en), 32'd0);
        chk_cursor("np1f", 0, 0);

        // "HI", LF, BS
        char_in = 8'h48;
        tick;
        chk_write("h", 12'd0, 8'h48);
        char_in = 8'h49;
        tick;
        chk_write("i", 12'd1, 8'h49);
        char_in = 8'h0A;
        tick;
        chk("lf_wr_en", 32'(wr_en), 32'd0);
`ifdef TEXT_CELL_CTRL_EN
        chk_cursor("lf", 0, 1);
`else
        chk_cursor("lf", 2, 0);
`endif
        char_in = 8'h08;
        tick;
        chk("bs_wr_en", 32'(wr_en), 32'd0);
`ifdef TEXT_CELL_CTRL_EN
        chk_cursor("bs", 0, 1);
`else
        chk_cursor("bs", 2, 0);
`endif
        char_valid = 1'b0;
        tick;

        // Clear collides with a pending byte
        clear_req = 1'b1; char_valid = 1'b1; char_in = 8'h43;
        #1;
        chk("collide_ready", 32'(char_ready), 32'd0);
        tick;
        clear_req = 1'b0;
        chk("clr_state", 32'(dbg_state), 32'd1);
        chk("clr_ready", 32'(char_ready), 32'd0);
        seq_err = 0;
        for (int i = 0; i < 2400; i++) begin
            if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== 8'h20 || busy !== 1'b1)
                seq_err++;
            if (i == 500) clear_req = 1'b1;
            tick;
            clear_req = 1'b0;
        end
        chk("clr_seq_errors", 32'(seq_err), 32'd0);
        chk("clr_end_busy", 32'(busy), 32'd0);
        chk("clr_end_wr_en", 32'(wr_en), 32'd0);
        chk("clr_end_ready", 32'(char_ready), 32'd1);
        chk_cursor("clr_end", 0, 0);
        tick;
        char_valid = 1'b0;
        chk_write("held_c", 12'd0, 8'h43);
        chk_cursor("held_c", 1, 0);
        tick;

        // Reset in the middle of a clear
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        repeat (1000) @(posedge Clk);
        #1;
        chk("abort_addr", 32'(wr_addr), 32'd1000);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_addr0", 32'(wr_addr), 32'd0);
        chk("abort_data", 32'(wr_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(char_ready), 32'd0);
        chk_cursor("abort", 0, 0);
        tick;
        tick;
        Reset = 1'b1;
        seq_err = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (wr_en !== 1'b0 || busy !== 1'b0) seq_err++;
        end
        chk("post_abort_quiet", 32'(seq_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
